ldst_mem_ctrl: RTL and testbench



---
 rtl/ldst_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ldst_mem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_mem_ctrl.sv
// ldst_mem_ctrl: commit-side data-memory responder between the ROB head and the d-cache.
// Accepts a level load/store request, issues one word-aligned d-cache access with byte
// enables, and returns a one-cycle data_mem_resp with the extended load result.
// Optional feature macro: LDST_MISALIGN_TRAP_EN. When defined, misaligned or illegal
// accesses are answered immediately with misalign_err and never reach the d-cache.
// When undefined, low address bits are forced to natural alignment.
module ldst_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [2:0]  data_funct3,
  output logic        data_mem_resp,
  output logic [31:0] data_rdata,
  output logic        misalign_err,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_DRAIN} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      r_state;
  size_t       r_size;
  logic        r_is_store;
  logic        r_unsigned;
  logic [1:0]  r_off;

  size_t       w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_mbe;
  logic [31:0] w_wdata;
  logic        w_trap;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  // Decode the incoming request: access size, aligned lane offset, byte enables, store lanes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_size  = SZ_W;
    w_off   = 2'b00;
    w_mbe   = 4'b1111;
    w_wdata = data_wdata;
    unique case (data_funct3[1:0])
      2'b00:   w_size = SZ_B;
      2'b01:   w_size = SZ_H;
      default: w_size = SZ_W;   // 010 plus the 011/110/111 encodings behave as words
    endcase
    unique case (w_size)
      SZ_B: begin
        w_off   = data_addr[1:0];
        w_wdata = {4{data_wdata[7:0]}};
        if (data_write) w_mbe = 4'b0001 << w_off;
      end
      SZ_H: begin
        w_off   = {data_addr[1], 1'b0};   // bit 0 dropped: halves sit on even bytes
        w_wdata = {2{data_wdata[15:0]}};
        if (data_write) w_mbe = 4'b0011 << w_off;
      end
      default: begin
        w_off   = 2'b00;
        w_wdata = data_wdata;
        w_mbe   = 4'b1111;
      end
    endcase
  end

  // Trap qualifier: misaligned half/word or an encoding outside B/H/W/BU/HU.
`ifdef LDST_MISALIGN_TRAP_EN
  always_comb begin
    w_trap = (data_funct3 == 3'b011) || (data_funct3[2:1] == 2'b11) ||
             ((w_size == SZ_H) && data_addr[0]) ||
             ((w_size == SZ_W) && (data_addr[1:0] != 2'b00));
  end
`else
  always_comb begin
    w_trap = 1'b0;
  end
`endif

  // Select the addressed byte/half of the returned word and sign- or zero-extend it.
  always_comb begin
    w_byte     = 8'h00;
    w_load_ext = dmem_rdata;
    unique case (r_off)
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (r_size)
      SZ_B:    w_load_ext = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    w_load_ext = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  // Request FSM; every output is a register so no ROB input reaches the d-cache port combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_size        <= SZ_W;
      r_is_store    <= 1'b0;
      r_unsigned    <= 1'b0;
      r_off         <= 2'b00;
      dmem_read     <= 1'b0;
      dmem_write    <= 1'b0;
      dmem_address  <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_mbe      <= 4'b0000;
      data_mem_resp <= 1'b0;
      data_rdata    <= 32'h0;
      misalign_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      data_mem_resp <= 1'b0;
      misalign_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (data_write || data_read) begin
            r_is_store   <= data_write;   // store wins when both levels are high
            r_size       <= w_size;
            r_unsigned   <= data_funct3[2];
            r_off        <= w_off;
            dmem_address <= {data_addr[31:2], 2'b00};
            dmem_wdata   <= w_wdata;
            dmem_mbe     <= w_mbe;
            if (w_trap) begin
              data_mem_resp <= 1'b1;
              misalign_err  <= 1'b1;
              data_rdata    <= 32'h0;
              r_state       <= S_RESP;
            end else begin
              dmem_read  <= ~data_write;
              dmem_write <= data_write;
              r_state    <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (dmem_resp) begin
            dmem_read     <= 1'b0;
            dmem_write    <= 1'b0;
            data_mem_resp <= 1'b1;
            if (!r_is_store) data_rdata <= w_load_ext;
            r_state       <= S_RESP;
          end
        end
        S_RESP: r_state <= S_DRAIN;
        S_DRAIN: begin
          // The ROB keeps its request up one cycle after the response; wait it out.
          if (!data_read && !data_write) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldst_mem_ctrl.sv
// Self-checking bench for ldst_mem_ctrl: directed test-plan cases, an asynchronous
// reset mid-access, then randomized loads/stores against a byte-lane reference model.
module tb_ldst_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [2:0]  data_funct3;
  logic        data_mem_resp;
  logic [31:0] data_rdata;
  logic        misalign_err;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_rd_bursts = 0;
  int          n_wr_bursts = 0;
  logic [31:0] last_rdata = 32'h0;

  ldst_mem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .data_read     (data_read),
    .data_write    (data_write),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_funct3   (data_funct3),
    .data_mem_resp (data_mem_resp),
    .data_rdata    (data_rdata),
    .misalign_err  (misalign_err),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_address  (dmem_address),
    .dmem_wdata    (dmem_wdata),
    .dmem_mbe      (dmem_mbe),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe bursts so a re-issued access shows up as an extra burst.
  always @(posedge dmem_read)  n_rd_bursts++;
  always @(posedge dmem_write) n_wr_bursts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: natural-size arithmetic on byte lanes.
  task automatic model(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] rd,
                       output logic trap, output logic [31:0] e_addr,
                       output logic [31:0] e_wdata, output logic [31:0] e_rdata,
                       output logic [3:0] e_mbe);
    int          size;
    int          a;
    int          off;
    logic [31:0] mask;
    logic [31:0] v;
    size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    a      = int'(addr & 32'd3);
    off    = (a / size) * size;
    mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    e_addr = addr & ~32'd3;
    e_mbe  = st ? 4'(((1 << size) - 1) << off) : 4'hF;
    e_wdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
              (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    v = (rd >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    e_rdata = v;
`ifdef LDST_MISALIGN_TRAP_EN
    trap = ((a % size) != 0) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`else
    trap = 1'b0;
`endif
  endtask

  // One full ROB transaction: request, cache latency, response, drain, release.
  task automatic do_access(input string tag, input logic st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input int delay, input logic [31:0] rd);
    logic        trap;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic [3:0]  e_mbe;
    int          rd0;
    int          wr0;
    model(st, addr, wd, f3, rd, trap, e_addr, e_wdata, e_rdata, e_mbe);
    rd0 = n_rd_bursts;
    wr0 = n_wr_bursts;
    @(negedge clk);
    data_write  = st;
    data_read   = st ? 1'($urandom_range(1, 0)) : 1'b1;
    data_addr   = addr;
    data_wdata  = wd;
    data_funct3 = f3;
    @(negedge clk);
    if (trap) begin
      check({tag, "_trap_resp"}, 32'(data_mem_resp), 32'd1);
      check({tag, "_trap_err"}, 32'(misalign_err), 32'd1);
      check({tag, "_trap_nostrobe"}, 32'(dmem_read | dmem_write), 32'd0);
      check({tag, "_trap_rdata"}, data_rdata, 32'h0);
      last_rdata = 32'h0;
    end else begin
      check({tag, "_strobe"}, {30'd0, dmem_write, dmem_read}, st ? 32'd2 : 32'd1);
      check({tag, "_addr"}, dmem_address, e_addr);
      check({tag, "_mbe"}, 32'(dmem_mbe), 32'(e_mbe));
      if (st) check({tag, "_wdata"}, dmem_wdata, e_wdata);
      check({tag, "_early_resp"}, 32'(data_mem_resp), 32'd0);
      // ROB-side fields change while busy; the latched access must not move.
      data_addr   = $urandom;
      data_wdata  = $urandom;
      data_funct3 = 3'($urandom_range(7, 0));
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check({tag, "_held"}, {30'd0, dmem_write, dmem_read}, st ? 32'd2 : 32'd1);
        check({tag, "_held_addr"}, dmem_address, e_addr);
      end
      dmem_resp  = 1'b1;
      dmem_rdata = rd;
      @(negedge clk);
      dmem_resp  = 1'b0;
      dmem_rdata = $urandom;
      if (!st) last_rdata = e_rdata;
      check({tag, "_resp"}, 32'(data_mem_resp), 32'd1);
      check({tag, "_err"}, 32'(misalign_err), 32'd0);
      check({tag, "_strobe_drop"}, 32'(dmem_read | dmem_write), 32'd0);
      check({tag, "_rdata"}, data_rdata, last_rdata);
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(data_mem_resp), 32'd0);
    check({tag, "_drain_noissue"}, 32'(dmem_read | dmem_write), 32'd0);
    data_read  = 1'b0;
    data_write = 1'b0;
    @(negedge clk);
    check({tag, "_idle_noissue"}, 32'(dmem_read | dmem_write), 32'd0);
    check({tag, "_rd_bursts"}, 32'(n_rd_bursts - rd0), (!trap && !st) ? 32'd1 : 32'd0);
    check({tag, "_wr_bursts"}, 32'(n_wr_bursts - wr0), (!trap && st) ? 32'd1 : 32'd0);
    check({tag, "_rdata_hold"}, data_rdata, last_rdata);
  endtask

  initial begin
    int b0;
    rst         = 1'b1;
    data_read   = 1'b0;
    data_write  = 1'b0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    data_funct3 = 3'b010;
    dmem_rdata  = 32'h0;
    dmem_resp   = 1'b0;
    #3;
    check("rst_resp", 32'(data_mem_resp), 32'd0);
    check("rst_err", 32'(misalign_err), 32'd0);
    check("rst_strobes", 32'(dmem_read | dmem_write), 32'd0);
    check("rst_addr", dmem_address, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_mbe", 32'(dmem_mbe), 32'd0);
    check("rst_rdata", data_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the test plan.
    do_access("lw_1000", 1'b0, 32'h0000_1000, 32'h0, 3'b010, 3, 32'hDEAD_BEEF);
    do_access("lb_1003", 1'b0, 32'h0000_1003, 32'h0, 3'b000, 1, 32'h80FF_FFFF);
    do_access("lbu_1003", 1'b0, 32'h0000_1003, 32'h0, 3'b100, 0, 32'h80FF_FFFF);
    do_access("sh_2002", 1'b1, 32'h0000_2002, 32'h1234_ABCD, 3'b001, 2, 32'h0);
    do_access("lh_2002", 1'b0, 32'h0000_2002, 32'h0, 3'b001, 0, 32'h8001_7FFF);
    do_access("sb_2001", 1'b1, 32'h0000_2001, 32'h0000_00A5, 3'b000, 0, 32'h0);

    // Back-to-back loads: exactly two read bursts.
    b0 = n_rd_bursts;
    do_access("b2b_a", 1'b0, 32'h0000_0040, 32'h0, 3'b010, 0, 32'h1111_2222);
    do_access("b2b_b", 1'b0, 32'h0000_0044, 32'h0, 3'b010, 0, 32'h3333_4444);
    check("b2b_bursts", 32'(n_rd_bursts - b0), 32'd2);

    // Misaligned word: trapped with the macro, force-aligned without it.
    do_access("lw_3001", 1'b0, 32'h0000_3001, 32'h0, 3'b010, 1, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a busy load.
    @(negedge clk);
    data_read   = 1'b1;
    data_addr   = 32'h0000_4000;
    data_funct3 = 3'b010;
    @(negedge clk);
    check("rstb_strobe_up", 32'(dmem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstb_strobe_drop", 32'(dmem_read), 32'd0);
    check("rstb_no_resp", 32'(data_mem_resp), 32'd0);
    check("rstb_addr", dmem_address, 32'h0);
    data_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstb_quiet_resp", 32'(data_mem_resp), 32'd0);
      check("rstb_quiet_strobe", 32'(dmem_read | dmem_write), 32'd0);
    end
    last_rdata = 32'h0;
    do_access("post_rst_lw", 1'b0, 32'h0000_5008, 32'h0, 3'b010, 0, 32'h0BAD_F00D);

    // Randomized mix of widths, offsets, latencies and encodings.
    for (int n = 0; n < 40; n++) begin
      do_access("rnd", 1'($urandom_range(1, 0)), $urandom, $urandom,
                3'($urandom_range(7, 0)), int'($urandom_range(3, 0)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
